vco: RTL and testbench

VCO -- requirements
Module: vco

---
 rtl/vco.sv | 109 ++++++++++
 tb/tb_vco.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vco.sv
// rtl/vco.sv - behavioural voltage-controlled oscillator model (simulation only)
// Optional build macro VCO_PHASE_CONT_EN: frequency changes take effect only on clk_o rising edges.
module vco #(
    parameter real MIN_FREQ_HZ     = 100E3,
    parameter real MAX_FREQ_HZ     = 10E9,
    parameter int  RESOLUTION_BITS = 30
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic [RESOLUTION_BITS-1:0] voltage_ctrl_i,
    output logic                       clk_o
);
    timeunit 1ns;
    timeprecision 1fs;

    localparam real MIN_HALF_NS = 1.0e-6;
    localparam real CODE_MAX    = real'((64'd1 << RESOLUTION_BITS) - 64'd1);

    if (!(MIN_FREQ_HZ > 0.0)) begin : g_chk_min
        $fatal(1, "vco: MIN_FREQ_HZ must be greater than zero");
    end
    if (!(MAX_FREQ_HZ > MIN_FREQ_HZ)) begin : g_chk_max
        $fatal(1, "vco: MAX_FREQ_HZ must be greater than MIN_FREQ_HZ");
    end
    if (RESOLUTION_BITS < 1 || RESOLUTION_BITS > 32) begin : g_chk_bits
        $fatal(1, "vco: RESOLUTION_BITS must be within 1..32");
    end

    logic [RESOLUTION_BITS-1:0] ctrl_q;
    logic [RESOLUTION_BITS-1:0] w_ctrl_clean;

    // Unknown control bits read as 0 so the oscillator never sees X.
    always_comb begin
        w_ctrl_clean = '0;
        for (int i = 0; i < RESOLUTION_BITS; i++) begin
            w_ctrl_clean[i] = (voltage_ctrl_i[i] === 1'b1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ctrl_q <= '0;
        end else begin
            if ($isunknown(voltage_ctrl_i)) begin
                $warning("vco: X/Z on voltage_ctrl_i, unknown bits treated as 0");
            end
            ctrl_q <= w_ctrl_clean;
        end
    end

    // Endpoints are pinned explicitly so rounding can never move them.
    function automatic real half_period_ns(input logic [RESOLUTION_BITS-1:0] code);
        real f;
        real half;
        if ($isunknown(code) || code == '0) begin
            f = MIN_FREQ_HZ;
        end else if (&code) begin
            f = MAX_FREQ_HZ;
        end else begin
            f = MIN_FREQ_HZ + (MAX_FREQ_HZ - MIN_FREQ_HZ) * real'(code) / CODE_MAX;
            if (f < MIN_FREQ_HZ) f = MIN_FREQ_HZ;
            if (f > MAX_FREQ_HZ) f = MAX_FREQ_HZ;
        end
        half = 0.5e9 / f;
        if (half < MIN_HALF_NS) half = MIN_HALF_NS;
        return half;
    endfunction

    logic            r_clk      = 1'b0;
    logic            r_resample = 1'b1;
    longint unsigned r_gen      = 0;
    real             r_half_ns  = 0.5e9 / MIN_FREQ_HZ;
    event            e_expire;

    // Each armed timer carries a generation tag; bumping r_gen orphans any timer in flight.
    task automatic arm_timer(input longint unsigned gen, input real delay_ns);
        fork
            begin
                automatic longint unsigned my_gen = gen;
                automatic real             my_dly = delay_ns;
                #(my_dly);
                if (my_gen == r_gen) -> e_expire;
            end
        join_none
    endtask

    always begin : p_osc
        if (!arst_ni) begin
            r_gen      = r_gen + 1;
            r_clk      = 1'b0;
            r_resample = 1'b1;
            @(posedge arst_ni);
        end
`ifdef VCO_PHASE_CONT_EN
        if (r_clk || r_resample) r_half_ns = half_period_ns(ctrl_q);
`else
        r_half_ns = half_period_ns(ctrl_q);
`endif
        r_resample = 1'b0;
        r_gen      = r_gen + 1;
        arm_timer(r_gen, r_half_ns);
        @(e_expire or negedge arst_ni);
        if (arst_ni) r_clk = ~r_clk;
    end

    // Gating with the reset makes the fall on reset assertion take effect in the same timestep.
    assign clk_o = r_clk & arst_ni;

endmodule

// File: tb/tb_vco.sv
// tb/tb_vco.sv - self-checking bench for the vco oscillator model
module tb_vco;
    timeunit 1ns;
    timeprecision 1fs;

    localparam int              RB       = 30;
    localparam real             FMIN     = 100e3;
    localparam real             FMAX     = 10e9;
    localparam longint unsigned CODE_ALL = (64'd1 << RB) - 64'd1;
    localparam real             LIM_NS   = 25000.0;
    localparam real             FS       = 1.0e-6;

    logic          clk_i          = 1'b0;
    logic          arst_ni        = 1'b0;
    logic [RB-1:0] voltage_ctrl_i = '0;
    logic          clk_o;
    bit            clk_run        = 1'b1;

    int checks = 0;
    int errors = 0;

    vco #(
        .MIN_FREQ_HZ    (FMIN),
        .MAX_FREQ_HZ    (FMAX),
        .RESOLUTION_BITS(RB)
    ) dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .voltage_ctrl_i(voltage_ctrl_i),
        .clk_o         (clk_o)
    );

    always #5 if (clk_run) clk_i = ~clk_i;

    int      n_rise      = 0;
    realtime t_last_fall = -1.0;
    always @(posedge clk_o) n_rise++;
    always @(negedge clk_o) t_last_fall = $realtime;

    initial begin
        #100ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frequency law applied directly: fraction of full scale times span plus floor.
    function automatic real model_period_ns(input longint unsigned code);
        real frac;
        frac = real'(code) / real'(CODE_ALL);
        return 1.0e9 / (FMIN + (FMAX - FMIN) * frac);
    endfunction

    task automatic check_real(input string name, input real act, input real exp, input real tol);
        checks++;
        if (!(act >= exp - tol && act <= exp + tol)) begin
            errors++;
            $display("FAIL %s: got %.9f, want %.9f (tol %g)", name, act, exp, tol);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    event            e_timeout;
    longint unsigned wait_gen = 0;

    task automatic wait_edge(input bit rising, input real limit_ns, output bit ok, output realtime t);
        realtime t0;
        t0       = $realtime;
        wait_gen = wait_gen + 1;
        fork
            begin
                automatic longint unsigned g = wait_gen;
                automatic real             d = limit_ns;
                #(d);
                if (g == wait_gen) -> e_timeout;
            end
        join_none
        if (rising) @(posedge clk_o or e_timeout);
        else        @(negedge clk_o or e_timeout);
        t  = $realtime;
        ok = (t - t0) < limit_ns;
    endtask

    task automatic measure(output real period, output real hi, output real lo, output bit ok);
        realtime r0, f1, r2;
        bit      o1, o2, o3;
        wait_edge(1'b1, LIM_NS, o1, r0);
        wait_edge(1'b0, LIM_NS, o2, f1);
        wait_edge(1'b1, LIM_NS, o3, r2);
        hi     = f1 - r0;
        lo     = r2 - f1;
        period = r2 - r0;
        ok     = o1 & o2 & o3;
    endtask

    task automatic set_code(input longint unsigned c);
        voltage_ctrl_i = c[RB-1:0];
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        longint unsigned code;
        real             exp_ns;
        real             tol_ns;
    } vec_t;

    vec_t vecs[7];

    initial begin
        real     per, hi, lo, per0, per1, tgt, meas, err;
        bit      ok, reached, wrapped;
        realtime tr, t1, e1, e2, e3, e4;
        int      rise_snap;
        longint  cur, nxt, step, c1g;
        longint unsigned code;

        vecs[0] = '{code: 64'd0,         exp_ns: 10000.0,                  tol_ns: 2 * FS};
        vecs[1] = '{code: CODE_ALL,      exp_ns: 0.1,                      tol_ns: 2 * FS};
        vecs[2] = '{code: 64'd1 << 29,   exp_ns: 1.0e9 / 5.00005e9,        tol_ns: 1.0e-4 * (1.0e9 / 5.00005e9)};
        vecs[3] = '{code: 64'd1,         exp_ns: model_period_ns(1),       tol_ns: 2 * FS};
        vecs[4] = '{code: 64'd1 << 28,   exp_ns: model_period_ns(1 << 28), tol_ns: 2 * FS};
        vecs[5] = '{code: CODE_ALL - 1,  exp_ns: model_period_ns(CODE_ALL - 1), tol_ns: 2 * FS};
        vecs[6] = '{code: 64'd12345678,  exp_ns: model_period_ns(12345678), tol_ns: 2 * FS};

        // Reset held with the clock running and a full-scale control word.
        voltage_ctrl_i = '1;
        rise_snap = n_rise;
        repeat (20) @(negedge clk_i);
        check_bit("reset_clk_o_low", clk_o, 1'b0);
        check_bit("reset_no_rise", n_rise == rise_snap, 1'b1);
        check_bit("reset_ctrl_q_zero", dut.ctrl_q == '0, 1'b1);

        // Release at minimum frequency: first rise half a period later.
        voltage_ctrl_i = '0;
        #2;
        tr      = $realtime;
        arst_ni = 1'b1;
        wait_edge(1'b1, LIM_NS, ok, t1);
        check_bit("release_first_rise_seen", ok, 1'b1);
        check_real("release_first_rise_ns", t1 - tr, 5000.0, FS);
        measure(per, hi, lo, ok);
        check_bit("min_freq_measured", ok, 1'b1);
        check_real("min_freq_period_ns", per, 10000.0, 2 * FS);
        check_real("min_freq_duty_ns", hi - lo, 0.0, FS);

        // Table of fixed control words.
        for (int i = 0; i < 7; i++) begin
            set_code(vecs[i].code);
            check_bit($sformatf("vec%0d_ctrl_q", i), dut.ctrl_q == vecs[i].code[RB-1:0], 1'b1);
            measure(per, hi, lo, ok);
            check_bit($sformatf("vec%0d_measured", i), ok, 1'b1);
            check_real($sformatf("vec%0d_period_ns", i), per, vecs[i].exp_ns, vecs[i].tol_ns);
            check_real($sformatf("vec%0d_duty_ns", i), hi - lo, 0.0, FS * 1.001);
            if (i == 0) per0 = per;
            if (i == 3) per1 = per;
        end
        check_bit("monotonic_code0_vs_code1", per1 <= per0, 1'b1);

        // Random control words against the model.
        for (int i = 0; i < 20; i++) begin
            code = longint'({32'd0, $urandom()}) & CODE_ALL;
            set_code(code);
            measure(per, hi, lo, ok);
            check_bit($sformatf("rand%0d_measured", i), ok, 1'b1);
            check_real($sformatf("rand%0d_period_code_%0d", i, code), per, model_period_ns(code), 2.5 * FS);
            check_real($sformatf("rand%0d_duty", i), hi - lo, 0.0, FS * 1.001);
        end

        // Reset during a high phase at 1 GHz, clock stopped while held.
        c1g = $rtoi((1.0e9 - FMIN) / (FMAX - FMIN) * real'(CODE_ALL) + 0.5);
        set_code(c1g);
        measure(per, hi, lo, ok);
        check_real("one_ghz_period_ns", per, 1.0, 1.0e-4);
        wait_edge(1'b1, LIM_NS, ok, t1);
        #0.2;
        check_bit("mid_high_before_reset", clk_o, 1'b1);
        tr      = $realtime;
        arst_ni = 1'b0;
        #0.001;
        check_bit("reset_fall_immediate", clk_o, 1'b0);
        check_real("reset_fall_time_ns", t_last_fall, tr, 1.0e-9);
        rise_snap      = n_rise;
        clk_run        = 1'b0;
        voltage_ctrl_i = '0;
        #100;
        check_bit("reset_hold_no_toggle", n_rise == rise_snap, 1'b1);
        check_bit("reset_hold_clk_o_low", clk_o, 1'b0);
        check_bit("reset_hold_ctrl_q", dut.ctrl_q == '0, 1'b1);
        clk_run = 1'b1;
        #3;
        tr      = $realtime;
        arst_ni = 1'b1;
        wait_edge(1'b1, LIM_NS, ok, t1);
        check_real("rerelease_first_rise_ns", t1 - tr, 5000.0, FS);
        measure(per, hi, lo, ok);
        check_real("rerelease_period_ns", per, 10000.0, 2 * FS);

        // Full-scale step in the middle of a 5 us high phase.
        wait_edge(1'b1, LIM_NS, ok, t1);
        #100;
        voltage_ctrl_i = '1;
        wait_edge(1'b0, LIM_NS, ok, e1);
        wait_edge(1'b1, LIM_NS, ok, e2);
        wait_edge(1'b0, LIM_NS, ok, e3);
        wait_edge(1'b1, LIM_NS, ok, e4);
        check_real("step_old_high_ns", e1 - t1, 5000.0, FS);
`ifdef VCO_PHASE_CONT_EN
        check_real("step_old_low_ns", e2 - e1, 5000.0, FS);
        check_real("step_new_high_ns", e3 - e2, 0.05, FS);
        check_real("step_new_low_ns", e4 - e3, 0.05, FS);
`else
        check_real("step_new_low_ns", e2 - e1, 0.05, FS);
        check_real("step_new_high_ns", e3 - e2, 0.05, FS);
`endif
        check_bit("step_no_short_pulse",
                  (e2 - e1 >= 0.05 - FS) && (e3 - e2 >= 0.05 - FS) && (e4 - e3 >= 0.05 - FS), 1'b1);

        // Closed loop toward random targets.
        cur     = longint'(CODE_ALL);
        wrapped = 1'b0;
        set_code(cur);
        for (int t = 0; t < 100; t++) begin
            tgt     = FMIN + (2.0e9 - FMIN) * (real'($urandom()) / 4294967295.0);
            reached = 1'b0;
            for (int it = 0; it < 200 && !reached; it++) begin
                measure(per, hi, lo, ok);
                if (!ok) break;
                meas = 1.0e9 / per;
                err  = tgt - meas;
                if ((err < 0.0 ? -err : err) <= 1.0e-3 * tgt) begin
                    reached = 1'b1;
                end else begin
                    step = 1 + $rtoi((err < 0.0 ? -err : err) / 25.0);
                    nxt  = (err > 0.0) ? cur + step : cur - step;
                    if (nxt < 0 || nxt > longint'(CODE_ALL)) begin
                        wrapped = 1'b1;
                        nxt     = (nxt < 0) ? 0 : longint'(CODE_ALL);
                    end
                    cur = nxt;
                    set_code(cur);
                end
            end
            check_bit($sformatf("loop%0d_reached_%0.0fHz", t, tgt), reached, 1'b1);
        end
        check_bit("loop_word_never_wrapped", wrapped, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
